// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg : receiver register map, status bit positions and controller states
// Rev 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

   localparam logic [31:0] ADDR_DATA = 32'h0000_0000;
   localparam logic [31:0] ADDR_DIV  = 32'h0000_0004;
   localparam logic [31:0] ADDR_STAT = 32'h0000_0008;

   localparam int STAT_PEND_BIT = 0;
   localparam int STAT_BUSY_BIT = 1;

   typedef enum logic [2:0] {
      START    = 3'd0,
      CFG_DIV  = 3'd1,
      CFG_CLR  = 3'd2,
      POLL_REQ = 3'd3,
      POLL_CHK = 3'd4,
      READ_REQ = 3'd5,
      READ_CAP = 3'd6,
      CLEAR    = 3'd7
   } state_t;

   // A byte may only be fetched once the receiver has finished shifting it in.
   function automatic logic byte_ready(input logic [31:0] status);
      return status[STAT_PEND_BIT] & ~status[STAT_BUSY_BIT];
   endfunction

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// byte_fifo : power-of-two depth byte FIFO with combinational head and drop flag
// Rev 1.0
// ----------------------------------------------------------------------------
module byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   output logic [7:0]               head,
   output logic                     full,
   output logic                     empty,
   output logic                     drop,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot the incoming byte needs.
   assign do_push = push & (~full | do_pop);
   assign drop    = push & ~do_push;
   assign head    = mem[rd_ptr];
   assign level   = count;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_ctrl : configures and polls a UART receiver, buffering bytes in a FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter logic [31:0] CLK_DIV = 32'd8,
   parameter int          DEPTH   = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic                     uart_wen,
   output logic [31:0]              uart_addr,
   output logic [31:0]              uart_wdata,
   input  logic [31:0]              uart_rdata,
   output logic [7:0]               m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   input  logic                     ovf_clr
);

   state_t state;
   logic   push;
   logic   fifo_full;
   logic   fifo_empty;
   logic   fifo_drop;
   logic   unused_bits;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= START;
      end else begin
         case (state)
            START:    state <= CFG_DIV;
            CFG_DIV:  state <= CFG_CLR;
            CFG_CLR:  state <= POLL_REQ;
            POLL_REQ: state <= POLL_CHK;
            POLL_CHK: state <= byte_ready(uart_rdata) ? READ_REQ : POLL_REQ;
            READ_REQ: state <= READ_CAP;
            READ_CAP: state <= CLEAR;
            CLEAR:    state <= POLL_REQ;
            default:  state <= START;
         endcase
      end
   end

   always_comb begin
      uart_wen   = 1'b0;
      uart_addr  = 32'h0;
      uart_wdata = 32'h0;
      case (state)
         CFG_DIV: begin
            uart_wen   = 1'b1;
            uart_addr  = ADDR_DIV;
            uart_wdata = CLK_DIV;
         end
         CFG_CLR, CLEAR: begin
            uart_wen   = 1'b1;
            uart_addr  = ADDR_STAT;
         end
         POLL_REQ, POLL_CHK: begin
            uart_addr  = ADDR_STAT;
         end
         READ_REQ, READ_CAP: begin
            uart_addr  = ADDR_DATA;
         end
         default: begin
            uart_wen   = 1'b0;
         end
      endcase
   end

   // The data read issued in READ_REQ returns during READ_CAP.
   assign push = (state == READ_CAP);

   byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (uart_rdata[7:0]),
      .pop       (m_ready),
      .head      (m_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .drop      (fifo_drop),
      .level     (level)
   );

   assign m_valid = ~fifo_empty;

   // A drop in the same cycle as a clear request keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (fifo_drop) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

   assign unused_bits = &{1'b0, uart_rdata[31:8], fifo_full};

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_rx_ctrl : directed bench with a register-level receiver model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

   localparam int          DEPTH = 8;
   localparam logic [31:0] DIV   = 32'd8;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   uart_wen;
   logic [31:0]            uart_addr;
   logic [31:0]            uart_wdata;
   logic [31:0]            uart_rdata = 32'h0;
   logic [7:0]             m_data;
   logic                   m_valid;
   logic                   m_ready = 1'b0;
   logic [$clog2(DEPTH):0] level;
   logic                   overflow;
   logic                   ovf_clr = 1'b0;

   int errors = 0;
   int checks = 0;

   logic [7:0]  rx_data = 8'h00;
   logic        pending = 1'b0;
   logic        busy    = 1'b0;
   logic [31:0] div_reg = 32'h0;
   int          data_reads = 0;
   int          clr_writes = 0;

   always #5 clk = ~clk;

   uart_rx_ctrl #(
      .CLK_DIV (DIV),
      .DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .uart_wen   (uart_wen),
      .uart_addr  (uart_addr),
      .uart_wdata (uart_wdata),
      .uart_rdata (uart_rdata),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .level      (level),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
   );

   // Receiver register file: registered reads, status write clears pending.
   always @(posedge clk) begin
      if (!uart_wen) begin
         case (uart_addr)
            32'h0:   uart_rdata <= {24'h0, rx_data};
            32'h4:   uart_rdata <= div_reg;
            32'h8:   uart_rdata <= {30'h0, busy, pending};
            default: uart_rdata <= 32'h0;
         endcase
         if (uart_addr == 32'h0) data_reads = data_reads + 1;
      end else begin
         if (uart_addr == 32'h4) div_reg = uart_wdata;
         if (uart_addr == 32'h8) begin
            pending    = 1'b0;
            clr_writes = clr_writes + 1;
         end
      end
   end

   task automatic wait_read_cap(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (!uart_wen && uart_addr == 32'h0) begin
            @(negedge clk);
            ok = 1'b1;
         end
      end
   endtask

   task automatic wait_clear(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         if (!pending) ok = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, output bit ok);
      @(negedge clk);
      rx_data = b;
      pending = 1'b1;
      wait_clear(ok);
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (uart_wen !== 1'b0) begin errors++; $display("FAIL rst_wen: got %0b want 0", uart_wen); end
      checks++; if (uart_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", uart_addr); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mvalid: got %0b want 0", m_valid); end
      checks++; if (level !== '0) begin errors++; $display("FAIL rst_level: got %0d want 0", level); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %0b want 0", overflow); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (uart_wen !== 1'b1 || uart_addr !== 32'h4 || uart_wdata !== DIV) begin
         errors++; $display("FAIL cfg_div: got wen=%0b addr=%h wdata=%h want 1/4/%h", uart_wen, uart_addr, uart_wdata, DIV); end
      @(negedge clk);
      checks++; if (uart_wen !== 1'b1 || uart_addr !== 32'h8 || uart_wdata !== 32'h0) begin
         errors++; $display("FAIL cfg_clr: got wen=%0b addr=%h wdata=%h want 1/8/0", uart_wen, uart_addr, uart_wdata); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (uart_wen !== 1'b0 || uart_addr !== 32'h8) begin
            errors++; $display("FAIL poll_%0d: got wen=%0b addr=%h want 0/8", i, uart_wen, uart_addr); end
      end
      checks++; if (div_reg !== DIV) begin errors++; $display("FAIL div_reg: got %h want %h", div_reg, DIV); end
   endtask

   task automatic test_basic();
      int vcycles = 0;
      int lat = -1;
      int clr0;
      logic [7:0] got = 8'h00;
      m_ready = 1'b1;
      @(negedge clk);
      clr0 = clr_writes;
      rx_data = 8'hA5;
      pending = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (m_valid === 1'b1) begin
            if (vcycles == 0) begin lat = i + 1; got = m_data; end
            vcycles++;
         end
      end
      m_ready = 1'b0;
      checks++; if (got !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", got); end
      checks++; if (vcycles != 1) begin errors++; $display("FAIL basic_valid_len: got %0d want 1", vcycles); end
      checks++; if (lat < 1 || lat > 7) begin errors++; $display("FAIL basic_latency: got %0d want 1..7", lat); end
      checks++; if (clr_writes - clr0 != 1 || pending !== 1'b0) begin
         errors++; $display("FAIL basic_clear: got writes=%0d pending=%0b want 1/0", clr_writes - clr0, pending); end
   endtask

   task automatic test_busy();
      int reads0;
      bit ok;
      @(negedge clk);
      reads0  = data_reads;
      rx_data = 8'h5A;
      busy    = 1'b1;
      pending = 1'b1;
      repeat (20) @(negedge clk);
      checks++; if (data_reads != reads0) begin errors++; $display("FAIL busy_reads: got %0d want 0", data_reads - reads0); end
      checks++; if (level !== '0) begin errors++; $display("FAIL busy_level: got %0d want 0", level); end
      busy = 1'b0;
      wait_clear(ok);
      checks++; if (!ok) begin errors++; $display("FAIL busy_timeout: got pending=%0b want 0", pending); end
      checks++; if (data_reads - reads0 != 2) begin errors++; $display("FAIL busy_read_cnt: got %0d want 2", data_reads - reads0); end
      checks++; if (level !== 4'd1 || m_data !== 8'h5A) begin
         errors++; $display("FAIL busy_push: got level=%0d data=%h want 1/5a", level, m_data); end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      checks++; if (level !== '0) begin errors++; $display("FAIL busy_drain: got %0d want 0", level); end
   endtask

   task automatic test_overflow();
      bit ok;
      bit all_ok = 1'b1;
      logic [7:0] b;
      for (int i = 0; i <= DEPTH; i++) begin
         b = 8'h10 + 8'(i);
         send_byte(b, ok);
         all_ok &= ok;
      end
      checks++; if (!all_ok) begin errors++; $display("FAIL ovf_timeout: got ok=0 want 1"); end
      checks++; if (level !== 4'(DEPTH)) begin errors++; $display("FAIL ovf_level: got %0d want %0d", level, DEPTH); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'h10 + 8'(i);
         checks++; if (m_valid !== 1'b1 || m_data !== b) begin
            errors++; $display("FAIL ovf_order_%0d: got valid=%0b data=%h want 1/%h", i, m_valid, m_data, b); end
         m_ready = 1'b1;
         @(negedge clk);
      end
      m_ready = 1'b0;
      checks++; if (level !== '0 || m_valid !== 1'b0) begin
         errors++; $display("FAIL ovf_drained: got level=%0d valid=%0b want 0/0", level, m_valid); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %0b want 0", overflow); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      bit ok2;
      bit all_ok = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         send_byte(8'h20 + 8'(i), ok);
         all_ok &= ok;
      end
      checks++; if (!all_ok || level !== 4'(DEPTH) || overflow !== 1'b0) begin
         errors++; $display("FAIL full_fill: got ok=%0b level=%0d ovf=%0b want 1/%0d/0", all_ok, level, overflow, DEPTH); end
      rx_data = 8'h30;
      pending = 1'b1;
      wait_read_cap(ok);
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      wait_clear(ok2);
      checks++; if (!ok || !ok2) begin errors++; $display("FAIL pp_timeout: got %0b%0b want 11", ok, ok2); end
      checks++; if (level !== 4'(DEPTH) || overflow !== 1'b0) begin
         errors++; $display("FAIL pp_level: got level=%0d ovf=%0b want %0d/0", level, overflow, DEPTH); end
      checks++; if (m_data !== 8'h21) begin errors++; $display("FAIL pp_head: got %h want 21", m_data); end
      rx_data = 8'h31;
      pending = 1'b1;
      wait_read_cap(ok);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      checks++; if (!ok || overflow !== 1'b1 || level !== 4'(DEPTH)) begin
         errors++; $display("FAIL set_wins: got ok=%0b ovf=%0b level=%0d want 1/1/%0d", ok, overflow, level, DEPTH); end
      wait_clear(ok);
   endtask

   task automatic test_reset_mid();
      bit ok;
      int reads0;
      rx_data = 8'h40;
      pending = 1'b1;
      wait_read_cap(ok);
      checks++; if (!ok || uart_addr !== 32'h0 || uart_wen !== 1'b0) begin
         errors++; $display("FAIL mid_readcap: got ok=%0b addr=%h wen=%0b want 1/0/0", ok, uart_addr, uart_wen); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (level !== '0 || m_valid !== 1'b0 || overflow !== 1'b0 || uart_wen !== 1'b0 || uart_addr !== 32'h0) begin
         errors++; $display("FAIL mid_rst: got level=%0d valid=%0b ovf=%0b wen=%0b addr=%h want 0/0/0/0/0",
                            level, m_valid, overflow, uart_wen, uart_addr); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (uart_wen !== 1'b1 || uart_addr !== 32'h4 || uart_wdata !== DIV) begin
         errors++; $display("FAIL mid_cfg_div: got wen=%0b addr=%h wdata=%h want 1/4/%h", uart_wen, uart_addr, uart_wdata, DIV); end
      @(negedge clk);
      checks++; if (uart_wen !== 1'b1 || uart_addr !== 32'h8) begin
         errors++; $display("FAIL mid_cfg_clr: got wen=%0b addr=%h want 1/8", uart_wen, uart_addr); end
      reads0 = data_reads;
      wait_clear(ok);
      repeat (12) @(negedge clk);
      checks++; if (!ok || level !== '0 || m_valid !== 1'b0 || data_reads != reads0) begin
         errors++; $display("FAIL mid_lost: got ok=%0b level=%0d valid=%0b reads=%0d want 1/0/0/0",
                            ok, level, m_valid, data_reads - reads0); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_busy();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
